// File: rtl/multicycle_alu.sv
// multicycle_alu: RV32I execute ALU with single-cycle ops, iterative shifts and valid/ready handshakes
module multicycle_alu #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t      state_q, state_d;
    logic [31:0] res_q, res_d, alu_r, shifted;
    logic        zero_q, ill_q, ill_d, accept, is_shift;
    logic [1:0]  sop_q, sop_d;
    logic [4:0]  rem_q, rem_d, amt, n;

    assign accept   = in_valid && in_ready;
    assign n        = src_b[4:0];
    assign is_shift = alu_ctrl == 4'd2 || alu_ctrl == 4'd6 || alu_ctrl == 4'd7;
    assign amt      = rem_q < STEP ? rem_q : STEP;
    // sop_q: bit 1 selects right shift, bit 0 selects arithmetic fill
    assign shifted  = sop_q[1] ? (sop_q[0] ? 32'($signed(res_q) >>> amt) : res_q >> amt) : res_q << amt;
    assign result   = res_q;
    assign zero     = zero_q;
    assign illegal  = ill_q;

    always_comb begin
        case (alu_ctrl)
            4'd0:             alu_r = src_a + src_b;
            4'd1:             alu_r = src_a - src_b;
            4'd2, 4'd6, 4'd7: alu_r = src_a;
            4'd3:             alu_r = {31'b0, $signed(src_a) < $signed(src_b)};
            4'd4:             alu_r = {31'b0, src_a < src_b};
            4'd5:             alu_r = src_a ^ src_b;
            4'd8:             alu_r = src_a | src_b;
            4'd9:             alu_r = src_a & src_b;
            4'd10:            alu_r = src_b;
            default:          alu_r = 32'b0;
        endcase
    end

    always_comb begin
        res_d = res_q;
        ill_d = ill_q;
        sop_d = sop_q;
        rem_d = rem_q;
        if (state_q == IDLE && accept) begin
            res_d = alu_r;
            ill_d = alu_ctrl > 4'd10;
            sop_d = {alu_ctrl[2], alu_ctrl[0]};
            rem_d = is_shift ? n : 5'd0;
        end else if (state_q == SHIFT) begin
            res_d = shifted;
            rem_d = rem_q - amt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= 32'b0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
            sop_q   <= 2'b0;
            rem_q   <= 5'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= res_d == 32'b0;
            ill_q   <= ill_d;
            sop_q   <= sop_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (is_shift && n != 5'd0 ? SHIFT : DONE) : IDLE;
            SHIFT:   state_d = rem_q <= STEP ? DONE : SHIFT;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE && !rst;
        out_valid = state_q == DONE;
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: checks two ALU instances (SHIFT_STEP 1 and 4) against an arithmetic reference model
module tb_multicycle_alu;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [3:0]  alu_ctrl = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic        ir1, ov1, z1, il1, ir4, ov4, z4, il4;
    logic [31:0] res1, res4;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.SHIFT_STEP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .alu_ctrl(alu_ctrl),
        .src_a(src_a), .src_b(src_b), .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .zero(z1), .illegal(il1)
    );
    multicycle_alu #(.SHIFT_STEP(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .alu_ctrl(alu_ctrl),
        .src_a(src_a), .src_b(src_b), .out_valid(ov4), .out_ready(out_ready),
        .result(res4), .zero(z4), .illegal(il4)
    );

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << n;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> n;
            4'd7:    return 32'($signed(a) >>> n);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input int n, input int s);
        return ((c == 4'd2 || c == 4'd6 || c == 4'd7) && n > 0) ? 1 + (n + s - 1) / s : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        d1, d4;
        int          n, k;
        er = model(c, a, b);
        n = int'(b[4:0]);
        in_valid = 1; alu_ctrl = c; src_a = a; src_b = b; out_ready = 1;
        #1;
        chk("in_ready_s1", 32'(ir1), 1);
        chk("in_ready_s4", 32'(ir4), 1);
        tick();
        in_valid = 0; src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
        d1 = 0; d4 = 0; k = 1;
        while (!(d1 && d4) && k <= 40) begin
            if (ov1 && !d1) begin
                d1 = 1;
                chk("latency_s1", k, exp_lat(c, n, 1));
                chk("result_s1", res1, er);
                chk("zero_s1", 32'(z1), 32'(er == 0));
                chk("illegal_s1", 32'(il1), 32'(c > 4'd10));
            end
            if (ov4 && !d4) begin
                d4 = 1;
                chk("latency_s4", k, exp_lat(c, n, 4));
                chk("result_s4", res4, er);
                chk("zero_s4", 32'(z4), 32'(er == 0));
                chk("illegal_s4", 32'(il4), 32'(c > 4'd10));
            end
            if (!(d1 && d4)) begin
                tick();
                k++;
            end
        end
        chk("completed", {30'b0, d1, d4}, 32'd3);
        tick();
    endtask

    initial begin
        logic seen;
        tick();
        tick();
        chk("rst_in_ready", 32'(ir1), 0);
        chk("rst_out_valid", 32'(ov1), 0);
        chk("rst_result", res1, 0);
        chk("rst_zero", 32'(z1), 1);
        chk("rst_illegal", 32'(il1), 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", 32'(ir1), 1);
        tick();

        run_op(4'd0, 32'h7FFFFFFF, 32'h00000001);
        run_op(4'd1, 32'd5, 32'd5);
        run_op(4'd3, 32'hFFFFFFFF, 32'd1);
        run_op(4'd4, 32'hFFFFFFFF, 32'd1);
        run_op(4'd10, 32'h12345678, 32'hABCDE000);
        run_op(4'd7, 32'h80000000, 32'hFFFFFFFF);
        run_op(4'd2, 32'hDEADBEEF, 32'hFFFFFFE0);
        run_op(4'd6, 32'hF0F0F0F0, 32'd7);
        run_op(4'd2, 32'h00000001, 32'd31);
        run_op(4'd5, 32'hAAAA5555, 32'hFFFF0000);
        run_op(4'd8, 32'h0000F0F0, 32'h0F0F0000);
        run_op(4'd9, 32'hFF00FF00, 32'h0FF00FF0);
        run_op(4'd12, 32'h11111111, 32'h22222222);
        run_op(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 40; i++)
            run_op(4'($urandom_range(0, 15)), $urandom, (i % 2 == 0) ? 32'($urandom_range(0, 31)) : $urandom);

        in_valid = 1; alu_ctrl = 4'd0; src_a = 32'd3; src_b = 32'd4; out_ready = 0;
        tick();
        alu_ctrl = 4'd1; src_a = 32'd99; src_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(ov1), 1);
            chk("hold_result", res1, 32'd7);
            chk("hold_in_ready_s1", 32'(ir1), 0);
            chk("hold_in_ready_s4", 32'(ir4), 0);
            tick();
        end
        in_valid = 0; out_ready = 1;
        chk("hold_release_result", res1, 32'd7);
        tick();
        chk("after_handshake_out_valid", 32'(ov1), 0);
        chk("after_handshake_in_ready", 32'(ir1), 1);

        in_valid = 1; alu_ctrl = 4'd6; src_a = 32'hF0000000; src_b = 32'd20; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        tick();
        chk("mid_shift_out_valid_s1", 32'(ov1), 0);
        chk("mid_shift_out_valid_s4", 32'(ov4), 0);
        rst = 1; in_valid = 1; alu_ctrl = 4'd0; src_a = 32'd1; src_b = 32'd2;
        #1;
        chk("rst_high_in_ready_s1", 32'(ir1), 0);
        chk("rst_high_in_ready_s4", 32'(ir4), 0);
        tick();
        rst = 0; in_valid = 0;
        #1;
        chk("midrst_result_s1", res1, 0);
        chk("midrst_result_s4", res4, 0);
        chk("midrst_zero", 32'(z1 & z4), 1);
        chk("midrst_illegal", 32'(il1 | il4), 0);
        chk("midrst_in_ready", 32'(ir1 & ir4), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | ov1 | ov4;
            tick();
        end
        chk("dropped_op_no_out_valid", 32'(seen), 0);

        run_op(4'd0, 32'd10, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execute-stage ALU of the core_v1 RV32I datapath, directly downstream of the ALU control decoder: it consumes the 4-bit `alu_ctrl` code plus two 32-bit operands and returns a registered result and zero flag. Shifts run iteratively on a small barrel (`SHIFT_STEP` bits per cycle) to save area; all other operations complete in one cycle. Valid/ready handshakes on both sides let the control FSM stall on multi-cycle shifts.

## Interface
- `SHIFT_STEP`, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands and `alu_ctrl` are valid.
- `in_ready`  output  1  block accepts an op this cycle.
- `alu_ctrl`  input  4  operation code (see Operation).
- `src_a`  input  32  operand A.
- `src_b`  input  32  operand B; `src_b[4:0]` is the shift amount.
- `out_valid`  output  1  `result`/`zero`/`illegal` are valid.
- `out_ready`  input  1  consumer takes the result.
- `result`  output  32  registered result.
- `zero`  output  1  registered, equals (`result` == 0).
- `illegal`  output  1  registered, op code was unassigned.
- One clock; reset is synchronous and active-high.

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B (LUI: `result = src_b`).
- 1011–1111: `result = 0`, `zero = 1`, `illegal = 1`, single-cycle latency; `illegal = 0` for all legal codes.
- ADD/SUB modulo 2^32, no carry/overflow output. SLT/SLTU: `result = {31'b0, lt}`.
- Branch use: BEQ/BNE arrive as SUB and use `zero`; BLT/BGE and BLTU/BGEU arrive as SLT/SLTU and use `result[0]`.
- Shifts: amount n = `src_b[4:0]`, `src_b[31:5]` ignored; SRA fills with the original `src_a[31]`.
- Operands and code are captured on acceptance (`in_valid && in_ready`); later input changes have no effect.
- FSM states:
  - IDLE: `in_ready = 1`. On acceptance of a non-shift op, or a shift with n = 0 (`result = src_a`), load result → DONE. On a shift with n > 0, load the shift register with `src_a` and remaining = n → SHIFT.
  - SHIFT: each cycle shift by min(`SHIFT_STEP`, remaining) and decrement remaining. When remaining reaches 0, go to DONE; the register already holds the final value.
  - DONE: `out_valid = 1`; `result`, `zero` and `illegal` stay stable. On `out_ready` go to IDLE.
- No acceptance outside IDLE (`in_ready = 0` in SHIFT and DONE); no result→input bypass.

## Timing
- Reset values: state IDLE, `out_valid = 0`, `result = 0`, `zero = 1`, `illegal = 0`. `in_ready = 0` in any cycle where `rst` is high, and 1 in the first cycle after reset is released.
- Op accepted in cycle T:
  - non-shift, illegal, or shift with n = 0: `out_valid` is high from T+1.
  - shift with n > 0: `out_valid` is high from T+1+ceil(n/`SHIFT_STEP`).
- Output handshake in cycle D (`out_valid && out_ready`): `out_valid = 0` and `in_ready = 1` in D+1. Peak throughput is one op per 2 cycles.
- `out_ready` held low: DONE persists indefinitely with outputs frozen.
- `in_valid` high outside IDLE: ignored; the source must hold its op until `in_ready`.
- `rst` during SHIFT or DONE: the op is dropped, and no `out_valid` pulse is produced for it. Reset values apply from the next cycle.
- `rst` together with `in_valid`: the op is not accepted.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `result = 0x80000000`, `zero = 0`, `out_valid` at T+1. SUB 5 − 5 → `result = 0`, `zero = 1`.
- SLT −1 vs 1 → `result = 1`; SLTU 0xFFFFFFFF vs 1 → `result = 0`. PASS_B with `src_b = 0xABCDE000` → `result = 0xABCDE000`.
- SRA 0x80000000 by `src_b = 0xFFFFFFFF` (n = 31), `SHIFT_STEP = 1` → `result = 0xFFFFFFFF`, `out_valid` at T+32. Repeat with `SHIFT_STEP = 4` → `out_valid` at T+9. SLL by n = 0 → `result = src_a` at T+1.
- Hold `out_ready = 0` for 5 cycles in DONE → `result` stable and `in_ready = 0` throughout. Drive `in_valid` with new operands meanwhile → not accepted.
- Back-to-back ops with `out_ready = 1` → acceptances exactly 2 cycles apart; results in order and correct.
- Code 1100 → `illegal = 1`, `result = 0`, `zero = 1` at T+1. Assert `rst` mid-SRL (n = 20) → no `out_valid`, reset values next cycle, `in_ready = 1` the cycle after `rst` falls.
